universal_shift_reg: RTL and testbench
======================================

UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, register width in bits; legal range WIDTH >= 2.
REQ-002 The block SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 The block SHALL have port enable  input  1  when 1, the operation on mode is performed at the clock edge; when 0, all state holds.
REQ-005 The block SHALL have port mode  input  3  operation select, encoded per REQ-010.
REQ-006 The block SHALL have port data  input  WIDTH  parallel load value.
REQ-007 The block SHALL have port ser_in_msb  input  1  serial bit entering the MSB on a logical right shift.
REQ-008 The block SHALL have port ser_in_lsb  input  1  serial bit entering the LSB on a left shift.
REQ-009 The block SHALL have outputs dataout (output, WIDTH, register contents), ser_out (output, 1, registered bit expelled or rotated by the last shift/rotate), count (output, clog2(WIDTH+1), shifts since the last load/clear), and drained (output, 1, high when count == WIDTH).

Function
REQ-010 The mode encoding SHALL be 000 hold, 001 parallel load, 010 logical shift right, 011 shift left, 100 rotate right, 101 rotate left, 110 clear, 111 arithmetic shift right.
REQ-011 Hold SHALL leave dataout, ser_out and count unchanged.
REQ-012 Load SHALL set dataout <= data and count <= 0, leaving ser_out unchanged.
REQ-013 Logical shift right SHALL set dataout <= {ser_in_msb, dataout[WIDTH-1:1]} and ser_out <= dataout[0].
REQ-014 Shift left SHALL set dataout <= {dataout[WIDTH-2:0], ser_in_lsb} and ser_out <= dataout[WIDTH-1].
REQ-015 Rotate right SHALL set dataout <= {dataout[0], dataout[WIDTH-1:1]} and ser_out <= dataout[0]; serial inputs are ignored.
REQ-016 Rotate left SHALL set dataout <= {dataout[WIDTH-2:0], dataout[WIDTH-1]} and ser_out <= dataout[WIDTH-1].
REQ-017 Arithmetic shift right SHALL set dataout <= {dataout[WIDTH-1], dataout[WIDTH-1:1]} and ser_out <= dataout[0].
REQ-018 Clear SHALL set dataout <= 0, ser_out <= 0 and count <= 0.
REQ-019 Every shift or rotate (modes 010-101, 111) SHALL increment count by 1, saturating at WIDTH; at saturation, shifting continues normally and count stays at WIDTH.
REQ-020 drained SHALL be a combinational decode of count (no extra cycle of latency).
REQ-021 All register updates SHALL take effect at the rising edge where enable=1, so results are visible one cycle after mode is applied; there is no other latency.
REQ-022 With enable=0, no register SHALL change regardless of mode, data or serial inputs.
REQ-023 A load or clear while drained=1 SHALL return count to 0 and deassert drained in the same cycle the new dataout appears.

Reset
REQ-024 When reset=0, dataout, ser_out and count SHALL clear to 0 immediately, without waiting for a clock edge; drained is therefore 0.
REQ-025 While reset=0, the clock SHALL be ignored.
REQ-026 The first rising edge after reset returns to 1 SHALL perform the operation selected by mode and enable normally.
REQ-027 Reset asserted in the middle of a shift sequence SHALL discard the sequence; no partial state SHALL survive.

Verification (WIDTH=4)
REQ-028 Load 1011, then 4x logical shift right with ser_in_msb=0 -> dataout 0101, 0010, 0001, 0000; ser_out 1, 1, 0, 1; count 1, 2, 3, 4; drained=1 after the 4th shift; a 5th shift keeps count=4.
REQ-029 Load 1001, then rotate left -> dataout 0011, ser_out=1; 4 rotates in total -> dataout 1001, count=4.
REQ-030 Load 1000, then 2x arithmetic shift right -> dataout 1100, then 1110; ser_out 0, 0.
REQ-031 Clear, then 2x shift left with ser_in_lsb=1 -> dataout 0001, 0011; ser_out 0, 0; count 2.
REQ-032 enable=0 with mode=001 and data=1111 over 3 edges -> dataout, ser_out and count unchanged.
REQ-033 Drop reset to 0 between clock edges after 2 shifts -> dataout=0000, count=0, ser_out=0, drained=0 before the next edge; no change while clock toggles with reset still 0.

Source files
------------

// File: rtl/universal_shift_reg.sv
// Universal shift register: hold, load, shifts, rotates, clear and a
// saturating count of shifts since the last load/clear.
//
// Ports:
//   clock      - rising-edge clock
//   reset      - async active-low reset
//   enable     - 1 performs mode at the edge, 0 holds all state
//   mode       - 000 hold, 001 load, 010 lsr, 011 shl,
//                100 ror, 101 rol, 110 clear, 111 asr
//   data       - parallel load value
//   ser_in_msb - bit entering MSB on logical shift right
//   ser_in_lsb - bit entering LSB on shift left
//   dataout    - register contents
//   ser_out    - bit expelled/rotated by the last shift
//   count      - shifts since last load/clear, saturates at WIDTH
//   drained    - count == WIDTH
module universal_shift_reg #(
  parameter int WIDTH = 4,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] data,
  input  logic             ser_in_msb,
  input  logic             ser_in_lsb,
  output logic [WIDTH-1:0] dataout,
  output logic             ser_out,
  output logic [CW-1:0]    count,
  output logic             drained
);

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_LOAD = 3'b001;
  localparam logic [2:0] M_LSR  = 3'b010;
  localparam logic [2:0] M_SHL  = 3'b011;
  localparam logic [2:0] M_ROR  = 3'b100;
  localparam logic [2:0] M_ROL  = 3'b101;
  localparam logic [2:0] M_CLR  = 3'b110;
  localparam logic [2:0] M_ASR  = 3'b111;

  localparam logic [CW-1:0] FULL = CW'(WIDTH);

  logic             shifting;
  logic [WIDTH-1:0] shift_val;
  logic             shift_bit;

  always_comb begin
    shifting  = 1'b1;
    shift_val = dataout;
    shift_bit = dataout[0];
    unique case (mode)
      M_LSR: shift_val = {ser_in_msb, dataout[WIDTH-1:1]};
      M_SHL: begin
        shift_val = {dataout[WIDTH-2:0], ser_in_lsb};
        shift_bit = dataout[WIDTH-1];
      end
      M_ROR: shift_val = {dataout[0], dataout[WIDTH-1:1]};
      M_ROL: begin
        shift_val = {dataout[WIDTH-2:0], dataout[WIDTH-1]};
        shift_bit = dataout[WIDTH-1];
      end
      M_ASR: shift_val = {dataout[WIDTH-1], dataout[WIDTH-1:1]};
      M_HOLD, M_LOAD, M_CLR: shifting = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dataout <= '0;
      ser_out <= 1'b0;
      count   <= '0;
    end else if (enable) begin
      if (mode == M_LOAD) begin
        dataout <= data;
        count   <= '0;
      end else if (mode == M_CLR) begin
        dataout <= '0;
        ser_out <= 1'b0;
        count   <= '0;
      end else if (shifting) begin
        dataout <= shift_val;
        ser_out <= shift_bit;
        // shifting continues past WIDTH; only the count saturates
        if (count != FULL)
          count <= count + 1'b1;
      end
    end
  end

  assign drained = (count == FULL);

endmodule

// File: tb/tb_universal_shift_reg.sv
// Testbench for universal_shift_reg (WIDTH=4): directed vectors plus
// random operations checked against an arithmetic reference model.
module tb_universal_shift_reg;

  localparam int W    = 4;
  localparam int CW   = $clog2(W + 1);
  localparam int MASK = (1 << W) - 1;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic [2:0]    mode = 3'b000;
  logic [W-1:0]  data = '0;
  logic          ser_in_msb = 1'b0;
  logic          ser_in_lsb = 1'b0;
  logic [W-1:0]  dataout;
  logic          ser_out;
  logic [CW-1:0] count;
  logic          drained;

  int errors = 0;
  int checks = 0;

  int m_val = 0;
  int m_ser = 0;
  int m_cnt = 0;

  universal_shift_reg #(.WIDTH(W)) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .mode(mode),
    .data(data),
    .ser_in_msb(ser_in_msb),
    .ser_in_lsb(ser_in_lsb),
    .dataout(dataout),
    .ser_out(ser_out),
    .count(count),
    .drained(drained)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input int en, input int md, input int d,
                            input int msb, input int lsb);
    int top;
    if (en == 0) return;
    top = (m_val >> (W - 1)) & 1;
    case (md)
      0: ;
      1: begin m_val = d; m_cnt = 0; end
      2: begin m_ser = m_val & 1; m_val = (m_val >> 1) | (msb << (W - 1)); end
      3: begin m_ser = top; m_val = ((m_val << 1) | lsb) & MASK; end
      4: begin m_ser = m_val & 1; m_val = (m_val >> 1) | (m_ser << (W - 1)); end
      5: begin m_ser = top; m_val = ((m_val << 1) | top) & MASK; end
      6: begin m_val = 0; m_ser = 0; m_cnt = 0; end
      7: begin m_ser = m_val & 1; m_val = (m_val >> 1) | (top << (W - 1)); end
      default: ;
    endcase
    if (md >= 2 && md != 6 && m_cnt < W) m_cnt++;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_data"}, int'(dataout), m_val);
    chk({tag, "_ser"}, int'(ser_out), m_ser);
    chk({tag, "_cnt"}, int'(count), m_cnt);
    chk({tag, "_drn"}, int'(drained), int'(m_cnt == W));
  endtask

  task automatic step(input string tag, input int en, input int md,
                      input int d, input int msb, input int lsb);
    enable = en[0];
    mode = md[2:0];
    data = d[W-1:0];
    ser_in_msb = msb[0];
    ser_in_lsb = lsb[0];
    @(posedge clock);
    #1;
    model_step(en, md, d, msb, lsb);
    check_model(tag);
  endtask

  initial begin
    #2;
    chk("rst_data", int'(dataout), 0);
    chk("rst_ser", int'(ser_out), 0);
    chk("rst_cnt", int'(count), 0);
    chk("rst_drn", int'(drained), 0);
    @(negedge clock);
    reset = 1'b1;

    // load 1011, logical shift right x5 with msb=0
    step("l28", 1, 1, 4'b1011, 0, 0);
    step("s28a", 1, 2, 0, 0, 0);
    chk("v28a", int'(dataout), 4'b0101);
    chk("v28a_so", int'(ser_out), 1);
    step("s28b", 1, 2, 0, 0, 0);
    chk("v28b", int'(dataout), 4'b0010);
    step("s28c", 1, 2, 0, 0, 0);
    chk("v28c_so", int'(ser_out), 0);
    step("s28d", 1, 2, 0, 0, 0);
    chk("v28d", int'(dataout), 4'b0000);
    chk("v28d_drn", int'(drained), 1);
    step("s28e", 1, 2, 0, 0, 0);
    chk("v28e_cnt", int'(count), 4);

    // load while drained
    step("l23", 1, 1, 4'b0110, 0, 0);
    chk("v23_drn", int'(drained), 0);
    chk("v23_cnt", int'(count), 0);

    // rotate left
    step("l29", 1, 1, 4'b1001, 0, 0);
    step("r29a", 1, 5, 0, 1, 1);
    chk("v29a", int'(dataout), 4'b0011);
    chk("v29a_so", int'(ser_out), 1);
    for (int i = 0; i < 3; i++) step("r29", 1, 5, 0, 0, 0);
    chk("v29d", int'(dataout), 4'b1001);
    chk("v29d_cnt", int'(count), 4);

    // arithmetic shift right
    step("l30", 1, 1, 4'b1000, 0, 0);
    step("a30a", 1, 7, 0, 0, 0);
    chk("v30a", int'(dataout), 4'b1100);
    step("a30b", 1, 7, 0, 0, 0);
    chk("v30b", int'(dataout), 4'b1110);
    chk("v30b_so", int'(ser_out), 0);

    // clear, shift left with lsb=1
    step("c31", 1, 6, 4'b1111, 1, 1);
    step("s31a", 1, 3, 0, 0, 1);
    chk("v31a", int'(dataout), 4'b0001);
    step("s31b", 1, 3, 0, 0, 1);
    chk("v31b", int'(dataout), 4'b0011);
    chk("v31b_cnt", int'(count), 2);

    // enable low ignores a load
    for (int i = 0; i < 3; i++) step("e32", 0, 1, 4'b1111, 1, 1);
    chk("v32", int'(dataout), 4'b0011);

    // rotate right ignores serial inputs
    step("r15", 1, 4, 0, 0, 0);
    chk("v15", int'(dataout), 4'b1001);

    // async reset mid sequence
    step("l33", 1, 1, 4'b1011, 0, 0);
    step("s33a", 1, 2, 0, 1, 0);
    step("s33b", 1, 2, 0, 1, 0);
    #2;
    reset = 1'b0;
    #1;
    m_val = 0; m_ser = 0; m_cnt = 0;
    check_model("r33");
    enable = 1'b1;
    mode = 3'b001;
    data = 4'b1111;
    repeat (3) @(posedge clock);
    #1;
    check_model("r33h");
    reset = 1'b1;
    step("l26", 1, 1, 4'b0101, 0, 0);
    chk("v26", int'(dataout), 4'b0101);

    // random operations
    for (int i = 0; i < 300; i++) begin
      int en;
      en = ($urandom_range(0, 7) != 0) ? 1 : 0;
      step("rnd", en, int'($urandom_range(0, 7)),
           int'($urandom_range(0, MASK)),
           int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
